// File: rtl/event_arbiter_pkg.sv
// Shared definitions for the event arbiter: event codes, code width, FSM states.
package event_arbiter_pkg;

    localparam int EVT_W = 3;

    typedef logic [EVT_W-1:0] evt_code_t;

    localparam evt_code_t EVT_NONE  = 3'd0;
    localparam evt_code_t EVT_BACK  = 3'd1;
    localparam evt_code_t EVT_STOP  = 3'd2;
    localparam evt_code_t EVT_START = 3'd3;
    localparam evt_code_t EVT_PMODE = 3'd4;
    localparam evt_code_t EVT_GOAL  = 3'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/event_arbiter_if.sv
// Valid/ready event handshake between the arbiter (master) and the game fsm (slave).
interface event_arbiter_if;
    import event_arbiter_pkg::*;

    logic      evt_valid;
    logic      evt_ready;
    evt_code_t evt_code;

    modport master (
        output evt_valid,
        output evt_code,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        output evt_ready
    );

endinterface

// File: rtl/event_arbiter_goal_counter.sv
// Saturating pending-goal counter with sticky overflow flag.
// Optional goal lockout timer enabled by defining GOAL_LOCKOUT_EN.
module event_arbiter_goal_counter #(
    parameter int GOAL_W      = 3,
    parameter int LOCKOUT_CYC = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ev_goal,
    input  logic              mask_goal,
    input  logic              dec,
    output logic [GOAL_W-1:0] goal_pend,
    output logic              goal_ovf
);

    logic arrive;
    logic sat;

`ifdef GOAL_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_CYC + 1);

    logic [LW-1:0] lock_cnt;
    logic          lock_free;

    assign lock_free = (lock_cnt == '0);

    // Lockout window: restarted by every accepted goal, counts down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
        end else if (ev_goal && !mask_goal && lock_free) begin
            lock_cnt <= LW'(LOCKOUT_CYC);
        end else if (!lock_free) begin
            lock_cnt <= lock_cnt - 1'b1;
        end
    end

    assign arrive = ev_goal & ~mask_goal & lock_free;
`else
    logic unused_lockout;
    assign unused_lockout = (LOCKOUT_CYC != 0);
    assign arrive = ev_goal & ~mask_goal;
`endif

    assign sat = &goal_pend;

    // Count arrivals up and loads down; arrival and load together cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            goal_pend <= '0;
            goal_ovf  <= 1'b0;
        end else begin
            case ({arrive, dec})
                2'b10: begin
                    if (sat) goal_ovf  <= 1'b1;
                    else     goal_pend <= goal_pend + 1'b1;
                end
                2'b01: begin
                    if (goal_pend != '0) goal_pend <= goal_pend - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/event_arbiter.sv
// Event arbiter: latches one-cycle button/goal pulses and offers them one at a
// time to the game fsm over valid/ready with fixed priority
// back > stop > start > pmode > goal.
// Optional: define GOAL_LOCKOUT_EN to ignore goals inside a lockout window.
module event_arbiter
    import event_arbiter_pkg::*;
#(
    parameter int GOAL_W      = 3,
    parameter int LOCKOUT_CYC = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ev_back,
    input  logic                ev_stop,
    input  logic                ev_start,
    input  logic                ev_pmode,
    input  logic                ev_goal,
    input  logic                mask_goal,
    event_arbiter_if.master     evt_if,
    output logic [GOAL_W-1:0]   goal_pend,
    output logic                goal_ovf
);

    state_t    state;
    evt_code_t code_q;
    logic      valid_q;

    logic      back_pend, stop_pend, start_pend, pmode_pend;
    logic      load_en;
    evt_code_t sel;
    logic      take_back, take_stop, take_start, take_pmode, take_goal;

    assign evt_if.evt_valid = valid_q;
    assign evt_if.evt_code  = code_q;

    // A new event may be loaded when nothing is offered or the offer is accepted.
    assign load_en = (state == IDLE) || evt_if.evt_ready;

    // Fixed-priority pick from the registered (pre-edge) pending state.
    always_comb begin
        sel = EVT_NONE;
        if      (back_pend)        sel = EVT_BACK;
        else if (stop_pend)        sel = EVT_STOP;
        else if (start_pend)       sel = EVT_START;
        else if (pmode_pend)       sel = EVT_PMODE;
        else if (goal_pend != '0)  sel = EVT_GOAL;
    end

    assign take_back  = load_en && (sel == EVT_BACK);
    assign take_stop  = load_en && (sel == EVT_STOP);
    assign take_start = load_en && (sel == EVT_START);
    assign take_pmode = load_en && (sel == EVT_PMODE);
    assign take_goal  = load_en && (sel == EVT_GOAL);

    // Pending flags: a new pulse wins over the clear caused by loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            back_pend  <= 1'b0;
            stop_pend  <= 1'b0;
            start_pend <= 1'b0;
            pmode_pend <= 1'b0;
        end else begin
            back_pend  <= (back_pend  & ~take_back)  | ev_back;
            stop_pend  <= (stop_pend  & ~take_stop)  | ev_stop;
            start_pend <= (start_pend & ~take_start) | ev_start;
            pmode_pend <= (pmode_pend & ~take_pmode) | ev_pmode;
        end
    end

    event_arbiter_goal_counter #(
        .GOAL_W      (GOAL_W),
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) u_goal_counter (
        .clk       (clk),
        .rst       (rst),
        .ev_goal   (ev_goal),
        .mask_goal (mask_goal),
        .dec       (take_goal),
        .goal_pend (goal_pend),
        .goal_ovf  (goal_ovf)
    );

    // Offer FSM: hold the offered code until accepted, then chain or go idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            code_q  <= EVT_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (sel != EVT_NONE) begin
                        state   <= OFFER;
                        valid_q <= 1'b1;
                        code_q  <= sel;
                    end
                end
                OFFER: begin
                    if (evt_if.evt_ready) begin
                        if (sel != EVT_NONE) begin
                            code_q <= sel;
                        end else begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            code_q  <= EVT_NONE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    code_q  <= EVT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_arbiter.sv
// Directed self-checking bench for event_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_event_arbiter;

    logic       clk;
    logic       rst;
    logic       ev_back, ev_stop, ev_start, ev_pmode, ev_goal, mask_goal;
    logic [2:0] goal_pend;
    logic       goal_ovf;
    int         n_chk;
    int         n_fail;

    event_arbiter_if evt_if();

    event_arbiter #(
        .GOAL_W      (3),
        .LOCKOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ev_back   (ev_back),
        .ev_stop   (ev_stop),
        .ev_start  (ev_start),
        .ev_pmode  (ev_pmode),
        .ev_goal   (ev_goal),
        .mask_goal (mask_goal),
        .evt_if    (evt_if),
        .goal_pend (goal_pend),
        .goal_ovf  (goal_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ev_back = 1'b0; ev_stop = 1'b0; ev_start = 1'b0;
        ev_pmode = 1'b0; ev_goal = 1'b0; mask_goal = 1'b0; evt_if.evt_ready = 1'b0;
        tick(); tick();
        n_chk++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", evt_if.evt_valid); end
        n_chk++; if (evt_if.evt_code !== 3'd0) begin n_fail++; $display("FAIL reset_code got %0d exp 0", evt_if.evt_code); end
        n_chk++; if (goal_pend !== 3'd0) begin n_fail++; $display("FAIL reset_pend got %0d exp 0", goal_pend); end
        n_chk++; if (goal_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", goal_ovf); end
        // pulses during the reset cycle are ignored
        ev_back = 1'b1; ev_goal = 1'b1;
        tick();
        ev_back = 1'b0; ev_goal = 1'b0; rst = 1'b0;
        tick(); tick();
        n_chk++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ignore_valid got %b exp 0", evt_if.evt_valid); end
        n_chk++; if (goal_pend !== 3'd0) begin n_fail++; $display("FAIL reset_ignore_pend got %0d exp 0", goal_pend); end
    endtask

    task automatic test_single();
        do_reset();
        evt_if.evt_ready = 1'b1;
        ev_start = 1'b1;
        tick();
        ev_start = 1'b0;
        n_chk++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat1 got %b exp 0", evt_if.evt_valid); end
        tick();
        n_chk++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 3'd3) begin n_fail++; $display("FAIL single_offer got v=%b c=%0d exp v=1 c=3", evt_if.evt_valid, evt_if.evt_code); end
        tick();
        n_chk++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_code !== 3'd0) begin n_fail++; $display("FAIL single_idle got v=%b c=%0d exp v=0 c=0", evt_if.evt_valid, evt_if.evt_code); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        evt_if.evt_ready = 1'b0;
        ev_back = 1'b1; ev_stop = 1'b1; ev_goal = 1'b1;
        tick();
        ev_back = 1'b0; ev_stop = 1'b0; ev_goal = 1'b0;
        n_chk++; if (goal_pend !== 3'd1) begin n_fail++; $display("FAIL simul_pend1 got %0d exp 1", goal_pend); end
        for (int i = 0; i < 6; i++) tick();
        n_chk++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 3'd1) begin n_fail++; $display("FAIL simul_hold_back got v=%b c=%0d exp v=1 c=1", evt_if.evt_valid, evt_if.evt_code); end
        evt_if.evt_ready = 1'b1;
        tick();
        n_chk++; if (evt_if.evt_code !== 3'd2) begin n_fail++; $display("FAIL simul_stop got %0d exp 2", evt_if.evt_code); end
        tick();
        n_chk++; if (evt_if.evt_code !== 3'd5 || goal_pend !== 3'd0) begin n_fail++; $display("FAIL simul_goal got c=%0d p=%0d exp c=5 p=0", evt_if.evt_code, goal_pend); end
        tick();
        n_chk++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL simul_idle got %b exp 0", evt_if.evt_valid); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        evt_if.evt_ready = 1'b0;
        ev_goal = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        ev_goal = 1'b0;
        tick();
        n_chk++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 3'd5) begin n_fail++; $display("FAIL sat_offer got v=%b c=%0d exp v=1 c=5", evt_if.evt_valid, evt_if.evt_code); end
        n_chk++; if (goal_pend !== 3'd7) begin n_fail++; $display("FAIL sat_pend got %0d exp 7", goal_pend); end
        n_chk++; if (goal_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got %b exp 1", goal_ovf); end
        // draining one goal keeps the sticky overflow flag
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
        n_chk++; if (goal_pend !== 3'd6 || goal_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_drain got p=%0d o=%b exp p=6 o=1", goal_pend, goal_ovf); end
    endtask

    task automatic test_set_wins_clear();
        do_reset();
        evt_if.evt_ready = 1'b0;
        ev_goal = 1'b1;
        tick();                 // goal_pend -> 1
        tick();                 // goal loaded and a new goal counted: net 0
        ev_goal = 1'b0;
        n_chk++; if (evt_if.evt_code !== 3'd5 || goal_pend !== 3'd1) begin n_fail++; $display("FAIL swc_goal got c=%0d p=%0d exp c=5 p=1", evt_if.evt_code, goal_pend); end
        evt_if.evt_ready = 1'b1;
        tick();
        n_chk++; if (evt_if.evt_code !== 3'd5 || goal_pend !== 3'd0) begin n_fail++; $display("FAIL swc_goal2 got c=%0d p=%0d exp c=5 p=0", evt_if.evt_code, goal_pend); end
        tick();
        evt_if.evt_ready = 1'b0;
        // same for a flag: pmode pulse on its own load edge stays pending
        ev_pmode = 1'b1;
        tick();
        tick();
        ev_pmode = 1'b0;
        n_chk++; if (evt_if.evt_code !== 3'd4) begin n_fail++; $display("FAIL swc_pmode got %0d exp 4", evt_if.evt_code); end
        evt_if.evt_ready = 1'b1;
        tick();
        n_chk++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 3'd4) begin n_fail++; $display("FAIL swc_pmode2 got v=%b c=%0d exp v=1 c=4", evt_if.evt_valid, evt_if.evt_code); end
        tick();
        n_chk++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL swc_idle got %b exp 0", evt_if.evt_valid); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_mask();
        do_reset();
        evt_if.evt_ready = 1'b1;
        mask_goal = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ev_goal = 1'b1; tick(); ev_goal = 1'b0; tick();
        end
        n_chk++; if (goal_pend !== 3'd0 || evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL mask_drop got p=%0d v=%b exp p=0 v=0", goal_pend, evt_if.evt_valid); end
        mask_goal = 1'b0;
        evt_if.evt_ready = 1'b0;
        ev_back = 1'b1; tick(); ev_back = 1'b0;
        tick();                 // back offered, blocking the goal below
        ev_goal = 1'b1; tick(); ev_goal = 1'b0;
        mask_goal = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ev_goal = 1'b1; tick(); ev_goal = 1'b0;
        end
        n_chk++; if (goal_pend !== 3'd1) begin n_fail++; $display("FAIL mask_keep got %0d exp 1", goal_pend); end
        evt_if.evt_ready = 1'b1;
        tick();
        n_chk++; if (evt_if.evt_code !== 3'd5 || goal_pend !== 3'd0) begin n_fail++; $display("FAIL mask_deliver got c=%0d p=%0d exp c=5 p=0", evt_if.evt_code, goal_pend); end
        tick();
        n_chk++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL mask_idle got %b exp 0", evt_if.evt_valid); end
        mask_goal = 1'b0;
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        evt_if.evt_ready = 1'b0;
        ev_pmode = 1'b1; ev_goal = 1'b1;
        tick();
        ev_pmode = 1'b0;
        tick();
        ev_goal = 1'b0;
        n_chk++; if (evt_if.evt_code !== 3'd4 || goal_pend !== 3'd2) begin n_fail++; $display("FAIL rmo_pre got c=%0d p=%0d exp c=4 p=2", evt_if.evt_code, goal_pend); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_code !== 3'd0) begin n_fail++; $display("FAIL rmo_offer got v=%b c=%0d exp v=0 c=0", evt_if.evt_valid, evt_if.evt_code); end
        n_chk++; if (goal_pend !== 3'd0 || goal_ovf !== 1'b0) begin n_fail++; $display("FAIL rmo_goal got p=%0d o=%b exp p=0 o=0", goal_pend, goal_ovf); end
        tick();
        n_chk++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rmo_after got %b exp 0", evt_if.evt_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        evt_if.evt_ready = 1'b1;
        ev_back = 1'b1; ev_stop = 1'b1; ev_start = 1'b1; ev_pmode = 1'b1;
        tick();
        ev_back = 1'b0; ev_stop = 1'b0; ev_start = 1'b0; ev_pmode = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_chk++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 3'(i)) begin n_fail++; $display("FAIL b2b_%0d got v=%b c=%0d exp v=1 c=%0d", i, evt_if.evt_valid, evt_if.evt_code, i); end
        end
        tick();
        n_chk++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b exp 0", evt_if.evt_valid); end
        evt_if.evt_ready = 1'b0;
    endtask

`ifdef GOAL_LOCKOUT_EN
    task automatic test_lockout();
        do_reset();
        evt_if.evt_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            ev_back = (c == 0);
            ev_goal = (c == 0) || (c == 3) || (c == 9);
            tick();
        end
        ev_back = 1'b0; ev_goal = 1'b0;
        n_chk++; if (goal_pend !== 3'd2 || goal_ovf !== 1'b0) begin n_fail++; $display("FAIL lockout got p=%0d o=%b exp p=2 o=0", goal_pend, goal_ovf); end
    endtask
`endif

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_saturation();
        test_set_wins_clear();
        test_mask();
        test_reset_mid_offer();
        test_back_to_back();
`ifdef GOAL_LOCKOUT_EN
        test_lockout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/event_arbiter.md
Name: event_arbiter

Overview:
- Sits between the debounced one-pulse button/goal sensor events and the game fsm.
- Latches every single-cycle event so that none is lost when several arrive at once or while the fsm is busy.
- Presents exactly one event at a time over a valid/ready handshake, using fixed priority.
- Goal events are counted, not flagged, so that rapid consecutive goals are all delivered.

Parameters:
- GOAL_W, 3, width of the pending-goal counter; saturates at 2^GOAL_W-1.
- LOCKOUT_CYC, 50000000, goal lockout window in clk cycles; used only with GOAL_LOCKOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset (the long-press reset pulse).
- ev_back  in  1  one-cycle pulse, back.
- ev_stop  in  1  one-cycle pulse, pause.
- ev_start  in  1  one-cycle pulse, start.
- ev_pmode  in  1  one-cycle pulse, practice mode.
- ev_goal  in  1  one-cycle pulse, goal sensor.
- mask_goal  in  1  1 = discard incoming goal pulses (game paused or not running).
- evt_ready  in  1  fsm accepts the offered event this cycle.
- evt_valid  out  1  an event is offered.
- evt_code  out  3  0 none, 1 back, 2 stop, 3 start, 4 pmode, 5 goal.
- goal_pend  out  GOAL_W  number of goals pending, excluding any goal currently offered.
- goal_ovf  out  1  sticky flag: a goal was dropped because the counter was saturated.

Behaviour:
- Reset: all pending flags=0, goal_pend=0, goal_ovf=0, evt_valid=0, evt_code=0, state IDLE. Event pulses in the rst cycle are ignored. A reset mid-offer drops the offered event.
- Pending storage:
  - One flag each for back, stop, start and pmode.
  - Pulse at edge N sets the flag. A repeat pulse while the flag is set is merged.
  - Goal: at each edge goal_pend += (ev_goal & ~mask_goal), saturating. A pulse arriving at saturation sets goal_ovf.
- Priority: back > stop > start > pmode > goal.
- States:
  - IDLE (evt_valid=0): at each edge, if any flag is set or goal_pend>0, load the highest-priority pending event into evt_code and go to OFFER. Loading clears its flag, or decrements goal_pend.
  - OFFER (evt_valid=1): evt_code is held stable until evt_valid&evt_ready. No preemption by higher-priority arrivals.
  - At the handshake edge: load the next highest-priority pending event from the pre-edge pending state and stay in OFFER; if nothing is pending, go to IDLE with evt_code=0.
- Timing:
  - Pulse to evt_valid latency is 2 cycles from an idle start (pending register, then offer register).
  - With continuous ready, back-to-back events are delivered on consecutive cycles.
- Simultaneous events:
  - A pulse arriving on the same edge its flag is loaded is kept pending; set wins over clear.
  - A goal pulse on the same edge as a goal load leaves goal_pend unchanged; the loaded goal is offered.
- mask_goal affects only new arrivals; goals already pending are still delivered.
- evt_ready while in IDLE is ignored.

Optional Feature:
- Macro: GOAL_LOCKOUT_EN.
- When defined:
  - Each accepted goal pulse starts a down-counter of LOCKOUT_CYC cycles.
  - Goal pulses arriving while the counter is non-zero are discarded. They do not set goal_ovf.
  - rst clears the counter.
- When not defined: every unmasked goal pulse is counted; no lockout counter is instantiated.

Decomposition:
- Shared package holds:
  - the event code constants EVT_NONE=0, EVT_BACK=1, EVT_STOP=2, EVT_START=3, EVT_PMODE=4, EVT_GOAL=5;
  - the state encoding (IDLE, OFFER);
  - the 3-bit code width.
- The fsm imports the same package.
- One natural sub-module: goal_counter, containing the saturating up/down counter, overflow flag and optional lockout timer.
- Priority selection stays inline.

Test Plan:
- Single event: ev_start pulse at cycle 10 with ready=1 -> evt_valid=1, evt_code=3 in cycle 12 only; then IDLE.
- Simultaneous events: ev_back, ev_stop and ev_goal all pulse in cycle 5, ready held 0 until cycle 20 then 1 -> offers code 1 (held until cycle 20), then 2, then 5 on consecutive cycles; goal_pend ends at 0.
- Goal saturation: 9 goal pulses with ready=0, GOAL_W=3 -> 1 goal offered, goal_pend=7, goal_ovf=1.
- Set wins over clear: ev_goal pulses on the same edge a goal is loaded -> goal_pend unchanged.
- Goal mask: mask_goal=1 during 3 goal pulses -> goal_pend stays 0 and nothing is offered; a goal already pending before the mask is still delivered.
- Reset mid-offer: rst asserted while offering code 4 with 2 goals pending -> next cycle evt_valid=0, goal_pend=0, goal_ovf=0.
- Lockout (with GOAL_LOCKOUT_EN, LOCKOUT_CYC=8): goal pulses at cycles 0, 3 and 9 -> goal_pend counts 2.
